// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, controller state type and opcode classification helpers
// for the execute-stage ALU sequencing controller.
package alu_ctrl_pkg;

  localparam logic [7:0] OP_ADD      = 8'h00;
  localparam logic [7:0] OP_SUB      = 8'h01;
  localparam logic [7:0] OP_MUL      = 8'h02;
  localparam logic [7:0] OP_LDB      = 8'h10;
  localparam logic [7:0] OP_LDW      = 8'h11;
  localparam logic [7:0] OP_STB      = 8'h12;
  localparam logic [7:0] OP_STW      = 8'h13;
  localparam logic [7:0] OP_BEQ      = 8'h20;
  localparam logic [7:0] OP_JUMP     = 8'h21;
  localparam logic [7:0] OP_TLBWRITE = 8'h32;
  localparam logic [7:0] OP_IRET     = 8'h33;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW,
      OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_wb(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // System ops and illegal opcodes return a zero data word regardless of the ALU.
  function automatic logic has_result(input logic [7:0] op);
    return is_legal(op) && (op != OP_TLBWRITE) && (op != OP_IRET);
  endfunction

endpackage

// File: rtl/alu_mul_timer.sv
// Loadable down-counter that paces how long a MUL is held on the ALU inputs;
// done is high while the count is zero.
module alu_mul_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (count && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU sequencing controller: accepts one op, holds it on the ALU for its
// latency and returns the captured result. Optional counters: ALU_EXEC_CTRL_PERF_EN.
module alu_exec_ctrl #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 8,
  parameter int REG_IDX_W   = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_instr,
  input  logic [DATA_W-1:0]    req_val1,
  input  logic [DATA_W-1:0]    req_val2,
  input  logic [REG_IDX_W-1:0] req_dst,
  output logic [OP_W-1:0]      alu_instr,
  output logic [DATA_W-1:0]    alu_val1,
  output logic [DATA_W-1:0]    alu_val2,
  input  logic [DATA_W-1:0]    alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [REG_IDX_W-1:0] rsp_dst,
  output logic                 rsp_wb,
  output logic                 rsp_illegal
`ifdef ALU_EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);
  import alu_ctrl_pkg::*;

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  state_t                state_reg, state_next;
  logic [OP_W-1:0]       alu_instr_reg;
  logic [DATA_W-1:0]     alu_val1_reg, alu_val2_reg;
  logic [REG_IDX_W-1:0]  dst_reg;
  logic                  rsp_valid_reg, rsp_wb_reg, rsp_illegal_reg;
  logic [DATA_W-1:0]     rsp_data_reg;
  logic [REG_IDX_W-1:0]  rsp_dst_reg;
  logic                  accept, capture, timer_load, timer_count, timer_done, req_is_mul;

  assign req_is_mul = (req_instr == OP_MUL);

  alu_mul_timer #(.CNT_W(CNT_W)) u_mul_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (MUL_LOAD),
    .count    (timer_count),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    capture     = 1'b0;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_EXEC: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_MUL_WAIT: begin
        timer_count = 1'b1;
        if (timer_done) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          req_ready  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A new op may be taken in the same cycle the previous response drains.
    accept = req_valid && req_ready;
    if (accept) begin
      timer_load = req_is_mul;
      state_next = req_is_mul ? ST_MUL_WAIT : ST_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_instr_reg   <= '0;
      alu_val1_reg    <= '0;
      alu_val2_reg    <= '0;
      dst_reg         <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_dst_reg     <= '0;
      rsp_wb_reg      <= 1'b0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        alu_instr_reg <= req_instr;
        alu_val1_reg  <= req_val1;
        alu_val2_reg  <= req_val2;
        dst_reg       <= req_dst;
      end
      if (capture) begin
        rsp_valid_reg   <= 1'b1;
        rsp_data_reg    <= has_result(alu_instr_reg) ? alu_out : '0;
        rsp_dst_reg     <= dst_reg;
        rsp_wb_reg      <= is_wb(alu_instr_reg);
        rsp_illegal_reg <= !is_legal(alu_instr_reg);
      end else if ((state_reg == ST_RESP) && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_instr   = alu_instr_reg;
  assign alu_val1    = alu_val1_reg;
  assign alu_val2    = alu_val2_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_dst     = rsp_dst_reg;
  assign rsp_wb      = rsp_wb_reg;
  assign rsp_illegal = rsp_illegal_reg;

`ifdef ALU_EXEC_CTRL_PERF_EN
  logic [31:0] perf_ops_reg, perf_stall_reg;

  // Stall = waiting on the consumer in RESP, or holding a MUL on the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops_reg   <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (rsp_valid_reg && rsp_ready) begin
        perf_ops_reg <= perf_ops_reg + 32'd1;
      end
      if (((state_reg == ST_RESP) && !rsp_ready) || (state_reg == ST_MUL_WAIT)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_reg;
  assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios plus randomized traffic
// checked against a transaction/latency-level reference model.
module tb_alu_exec_ctrl;

  localparam int DATA_W      = 32;
  localparam int OP_W        = 8;
  localparam int REG_IDX_W   = 5;
  localparam int MUL_LATENCY = 3;

  localparam logic [7:0] T_ADD = 8'h00, T_SUB = 8'h01, T_MUL = 8'h02, T_LDB = 8'h10;
  localparam logic [7:0] T_LDW = 8'h11, T_STB = 8'h12, T_STW = 8'h13, T_BEQ = 8'h20;
  localparam logic [7:0] T_JUMP = 8'h21, T_TLB = 8'h32, T_IRET = 8'h33;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid, req_ready;
  logic [OP_W-1:0]      req_instr;
  logic [DATA_W-1:0]    req_val1, req_val2;
  logic [REG_IDX_W-1:0] req_dst;
  logic [OP_W-1:0]      alu_instr;
  logic [DATA_W-1:0]    alu_val1, alu_val2, alu_out;
  logic                 rsp_valid, rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic [REG_IDX_W-1:0] rsp_dst;
  logic                 rsp_wb, rsp_illegal;
`ifdef ALU_EXEC_CTRL_PERF_EN
  logic [31:0]          perf_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_exec_ctrl #(
    .DATA_W(DATA_W), .OP_W(OP_W), .REG_IDX_W(REG_IDX_W), .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_val1(req_val1), .req_val2(req_val2), .req_dst(req_dst),
    .alu_instr(alu_instr), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dst(rsp_dst), .rsp_wb(rsp_wb), .rsp_illegal(rsp_illegal)
`ifdef ALU_EXEC_CTRL_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  // Environment ALU: whatever the real ALU computes for each opcode.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      T_SUB:   return a - b;
      T_MUL:   return a * b;
      T_BEQ:   return (a == b) ? 32'd1 : 32'd0;
      T_ADD, T_LDB, T_LDW, T_STB, T_STW, T_JUMP: return a + b;
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_out = ref_alu(alu_instr, alu_val1, alu_val2);

  function automatic bit op_legal(input logic [7:0] op);
    return op inside {T_ADD, T_SUB, T_MUL, T_LDB, T_LDW, T_STB, T_STW, T_BEQ, T_JUMP, T_TLB, T_IRET};
  endfunction

  function automatic bit op_wb(input logic [7:0] op);
    return op inside {T_ADD, T_SUB, T_MUL, T_LDB, T_LDW};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: at most one op in flight, response due a fixed latency after accept.
  int          cyc = 0;
  bit          outstanding = 1'b0;
  int          due = 0;
  logic [31:0] e_data;
  logic [4:0]  e_dst;
  bit          e_wb, e_ill;
  logic [71:0] last_alu = '0;
  int          n_rsp = 0;

  task automatic step(input bit v, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] d, input bit rr, input bit rst);
    bit resp_hs, acc;
    req_valid = v;  req_instr = op;  req_val1 = a;  req_val2 = b;  req_dst = d;
    rsp_ready = rr; rst_n = !rst;
    resp_hs = !rst && outstanding && (cyc >= due) && rr;
    acc     = !rst && v && (!outstanding || resp_hs);
    @(negedge clk);
    cyc++;
    if (rst) begin
      outstanding = 1'b0;
      last_alu    = '0;
    end else begin
      if (resp_hs) begin
        outstanding = 1'b0;
        n_rsp++;
        $display("rsp %0d: dst=%0d data=%08h wb=%0b ill=%0b", n_rsp, e_dst, e_data, e_wb, e_ill);
      end
      if (acc) begin
        outstanding = 1'b1;
        due      = cyc + ((op == T_MUL) ? MUL_LATENCY : 1);
        e_ill    = !op_legal(op);
        e_wb     = op_wb(op);
        e_data   = (op_legal(op) && op != T_TLB && op != T_IRET) ? ref_alu(op, a, b) : 32'd0;
        e_dst    = d;
        last_alu = {op, a, b};
      end
    end
    check_val("rsp_valid", rsp_valid, outstanding && (cyc >= due));
    check_val("req_ready", req_ready, !outstanding || ((cyc >= due) && rsp_ready));
    check_val("alu_inputs", {alu_instr, alu_val1, alu_val2}, last_alu);
    if (outstanding && (cyc >= due)) begin
      check_val("rsp_data", rsp_data, e_data);
      check_val("rsp_dst", rsp_dst, e_dst);
      check_val("rsp_wb", rsp_wb, e_wb);
      check_val("rsp_illegal", rsp_illegal, e_ill);
    end
  endtask

  task automatic idle(input bit rr);
    step(1'b0, T_ADD, 32'd0, 32'd0, 5'd0, rr, 1'b0);
  endtask

  logic [7:0] op_pool [12] = '{T_ADD, T_SUB, T_MUL, T_LDB, T_LDW, T_STB, T_STW,
                               T_BEQ, T_JUMP, T_TLB, T_IRET, 8'hFF};

  initial begin
    step(1'b0, T_ADD, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1'b0, T_ADD, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    check_val("reset_rsp_data", rsp_data, 32'd0);
    check_val("reset_rsp_flags", {rsp_dst, rsp_wb, rsp_illegal}, 7'd0);

    // ADD 5+7
    step(1'b1, T_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    check_val("add_data", rsp_data, 32'd12);
    check_val("add_dst_wb", {rsp_valid, rsp_dst, rsp_wb}, {1'b1, 5'd3, 1'b1});
    idle(1'b1);

    // MUL 6*7, held on the ALU for MUL_LATENCY cycles
    step(1'b1, T_MUL, 32'd6, 32'd7, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < MUL_LATENCY; i++) idle(1'b1);
    check_val("mul_data", rsp_data, 32'd42);
    idle(1'b1);

    // STW address, then an illegal opcode
    step(1'b1, T_STW, 32'h100, 32'h4, 5'd7, 1'b0, 1'b0);
    idle(1'b0);
    check_val("stw_data_wb", {rsp_data, rsp_wb}, {32'h104, 1'b0});
    idle(1'b1);
    step(1'b1, 8'hFF, 32'h11, 32'h22, 5'd4, 1'b0, 1'b0);
    idle(1'b0);
    check_val("ill_data_flag", {rsp_data, rsp_illegal, rsp_wb}, {32'd0, 1'b1, 1'b0});
    idle(1'b1);

    // Backpressure for 5 cycles, then back-to-back accept on the draining cycle
    step(1'b1, T_ADD, 32'd1, 32'd2, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0);
    step(1'b1, T_ADD, 32'd10, 32'd20, 5'd2, 1'b1, 1'b0);
    check_val("b2b_valid_drop", rsp_valid, 1'b0);
    idle(1'b1);
    check_val("b2b_data", rsp_data, 32'd30);
    idle(1'b1);

    // Reset during MUL_WAIT discards the op
    step(1'b1, T_MUL, 32'd3, 32'd3, 5'd5, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b0, T_ADD, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    check_val("midrst_state", {rsp_valid, req_ready, rsp_data}, {1'b0, 1'b1, 32'd0});
    for (int i = 0; i < 5; i++) idle(1'b1);

`ifdef ALU_EXEC_CTRL_PERF_EN
    step(1'b0, T_ADD, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1'b1, T_ADD, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    step(1'b1, T_MUL, 32'd2, 32'd3, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < MUL_LATENCY + 1; i++) idle(1'b1);
    step(1'b1, T_SUB, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0); idle(1'b0); idle(1'b1);
    check_val("perf_ops", perf_ops, 32'd3);
    check_val("perf_stall", perf_stall, 32'd5);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] op;
      op = op_pool[$urandom_range(0, 11)];
      if (op == 8'hFF) op = 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 7, op, $urandom, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
